// File: rtl/sbox_pkg.sv
// Shared constants for the S-box lookup engine.
// Default geometry and the lane slice width used to pack operands.
package sbox_pkg;

    localparam int W_DEF     = 7;
    localparam int LANES_DEF = 1;
    localparam int LANE_W    = W_DEF;

endpackage

// File: rtl/sbox_table.sv
// Forward and inverse S-box storage.
// One shared write port, LANES combinational read ports per table.
module sbox_table
    import sbox_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic [LANES*W-1:0] rd_addr,
    output logic [LANES*W-1:0] fwd_data,
    output logic [LANES*W-1:0] inv_data
);

    localparam int DEPTH = 1 << W;

    logic [W-1:0] fwd_mem [DEPTH];
    logic [W-1:0] inv_mem [DEPTH];

    // Paired write keeps inv as the inverse of fwd for a permutation
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fwd_mem[wr_addr] <= wr_data;
            inv_mem[wr_data] <= wr_addr;
        end
    end

    // Each lane reads both tables; the engine picks the direction
    always_comb begin
        fwd_data = '0;
        inv_data = '0;
        for (int k = 0; k < LANES; k++) begin
            fwd_data[k*W +: W] = fwd_mem[rd_addr[k*W +: W]];
            inv_data[k*W +: W] = inv_mem[rd_addr[k*W +: W]];
        end
    end

endmodule

// File: rtl/sbox_engine.sv
// Multi-lane S-box lookup engine with forward/inverse tables.
// Load counter gates lookups; one-deep output register with handshake.
module sbox_engine
    import sbox_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_addr,
    input  logic [W-1:0]       wr_data,
    output logic               tbl_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data
);

    logic [W:0]         wr_count;
    logic [LANES*W-1:0] fwd_rd;
    logic [LANES*W-1:0] inv_rd;
    logic [LANES*W-1:0] lookup;
    logic               accept;

    sbox_table #(
        .W     (W),
        .LANES (LANES)
    ) u_table (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (in_data),
        .fwd_data (fwd_rd),
        .inv_data (inv_rd)
    );

    // Top counter bit marks 2^W writes seen; it is also the saturation point
    assign tbl_ready = wr_count[W];
    assign in_ready  = tbl_ready & ~wr_en & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign lookup    = in_inv ? inv_rd : fwd_rd;

    // Count table writes, saturating once the table is fully loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_en && !wr_count[W]) begin
            wr_count <= wr_count + (W+1)'(1);
        end
    end

    // Output register: load on accept, hold under backpressure, drain on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sbox_engine.sv
// Self-checking bench for sbox_engine with a 4-lane, 7-bit configuration.
// Uses the KASUMI S7 table and an array-based reference of both tables.
module tb_sbox_engine;

    localparam int W  = 7;
    localparam int L  = 4;
    localparam int DW = W * L;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          wr_en     = 1'b0;
    logic [W-1:0]  wr_addr   = '0;
    logic [W-1:0]  wr_data   = '0;
    logic          tbl_ready;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          in_inv    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;

    int s7 [128] = '{
         54, 50, 62, 56, 22, 34, 94, 96, 38,  6, 63, 93,  2, 18,123, 33,
         55,113, 39,114, 21, 67, 65, 12, 47, 73, 46, 27, 25,111,124, 81,
         53,  9,121, 79, 52, 60, 58, 48,101,127, 40,120,104, 70, 71, 43,
         20,122, 72, 61, 23,109, 13,100, 77,  1, 16,  7, 82, 10,105, 98,
        117,116, 76, 11, 89,106,  0,125,118, 99, 86, 69, 30, 57,126, 87,
        112, 51, 17,  5, 95, 14, 90, 84, 91,  8, 35,103, 32, 97, 28, 66,
        102, 31, 26, 45, 75,  4, 85, 92, 37, 74, 80, 49, 68, 29,115, 44,
         64,107,108, 24,110, 83, 36, 78, 42, 19, 15, 41, 88,119, 59,  3
    };

    int fwd_m [128];
    int inv_m [128];

    sbox_engine #(
        .W     (W),
        .LANES (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tbl_ready (tbl_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pack4(int a, int b, int c, int d);
        logic [DW-1:0] r;
        r = {W'(d), W'(c), W'(b), W'(a)};
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_lookup(logic [DW-1:0] d, logic inv);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = int'(d[k*W +: W]);
            r[k*W +: W] = W'(inv ? inv_m[v] : fwd_m[v]);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_ops(logic inv);
        logic [DW-1:0] r;
        int x;
        r = '0;
        for (int k = 0; k < L; k++) begin
            x = int'($urandom_range(0, 127));
            r[k*W +: W] = W'(inv ? fwd_m[x] : x);
        end
        return r;
    endfunction

    task automatic wr(int a, int d);
        wr_en   = 1'b1;
        wr_addr = W'(a);
        wr_data = W'(d);
        fwd_m[a] = d;
        inv_m[d] = a;
    endtask

    task automatic load_all();
        for (int i = 0; i < 127; i++) begin
            wr(i, s7[i]);
            #1;
            chk("in_ready_loading", 32'(in_ready), 0);
            tick();
            chk("tbl_ready_early", 32'(tbl_ready), 0);
        end
        wr_en    = 1'b0;
        in_valid = 1'b1;
        in_data  = '0;
        #1;
        chk("in_ready_unloaded", 32'(in_ready), 0);
        tick();
        chk("no_accept_unloaded", 32'(out_valid), 0);
        in_valid = 1'b0;
        wr(127, s7[127]);
        #1;
        chk("tbl_ready_last_write", 32'(tbl_ready), 0);
        tick();
        wr_en = 1'b0;
        chk("tbl_ready_rise", 32'(tbl_ready), 1);
    endtask

    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          inv_r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_tbl_ready", 32'(tbl_ready), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_all();

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = pack4(0, 1, 2, 3);
        exp_a     = pack4(54, 50, 62, 56);
        #1;
        chk("fwd_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("fwd_valid", 32'(out_valid), 1);
        chk("fwd_lanes", 32'(out_data), 32'(exp_a));
        chk("fwd_lanes_model", 32'(out_data), 32'(ref_lookup(pack4(0, 1, 2, 3), 1'b0)));
        tick();
        chk("fwd_drain", 32'(out_valid), 0);

        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = pack4(54, 3, 50, 62);
        tick();
        in_valid = 1'b0;
        chk("inv_lanes", 32'(out_data), 32'(pack4(0, 127, 1, 2)));
        tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = pack4(1, 5, 6, 7);
        exp_a     = ref_lookup(in_data, 1'b0);
        tick();
        in_data = pack4(2, 8, 9, 10);
        exp_b   = ref_lookup(in_data, 1'b0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_lane0_50", 32'(out_data[W-1:0]), 50);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
            chk("bp_hold", 32'(out_data), 32'(exp_a));
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        chk("bp_release_data", 32'(out_data), 32'(exp_a));
        tick();
        in_valid = 1'b0;
        chk("bp_second", 32'(out_data), 32'(exp_b));
        chk("bp_lane0_62", 32'(out_data[W-1:0]), 62);
        chk("bp_second_valid", 32'(out_valid), 1);
        tick();
        chk("bp_drain", 32'(out_valid), 0);

        for (int i = 0; i < 16; i++) begin
            inv_r    = 1'($urandom_range(0, 1));
            in_inv   = inv_r;
            in_data  = rand_ops(inv_r);
            in_valid = 1'b1;
            exp_a    = ref_lookup(in_data, inv_r);
            #1;
            chk("stream_in_ready", 32'(in_ready), 1);
            tick();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_data", 32'(out_data), 32'(exp_a));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(out_valid), 0);

        in_valid = 1'b1;
        in_inv   = 1'b0;
        in_data  = pack4(0, 4, 5, 6);
        wr(0, 5);
        #1;
        chk("wr_prio_in_ready", 32'(in_ready), 0);
        tick();
        wr_en = 1'b0;
        chk("wr_prio_no_accept", 32'(out_valid), 0);
        exp_a = ref_lookup(in_data, 1'b0);
        tick();
        chk("wr_new_fwd", 32'(out_data), 32'(exp_a));
        chk("wr_new_fwd_lane0", 32'(out_data[W-1:0]), 5);
        in_inv  = 1'b1;
        in_data = pack4(5, fwd_m[20], fwd_m[40], fwd_m[60]);
        exp_a   = ref_lookup(in_data, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("wr_new_inv", 32'(out_data), 32'(exp_a));
        chk("wr_new_inv_lane0", 32'(out_data[W-1:0]), 0);
        tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = rand_ops(1'b0);
        exp_a     = ref_lookup(in_data, 1'b0);
        tick();
        in_valid = 1'b0;
        wr(int'(in_data[W-1:0]), 9);
        tick();
        wr_en = 1'b0;
        chk("held_after_write", 32'(out_data), 32'(exp_a));
        chk("held_valid", 32'(out_valid), 1);

        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_tbl_ready", 32'(tbl_ready), 0);
        chk("async_in_ready", 32'(in_ready), 0);
        chk("async_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = '0;
        #1;
        chk("post_rst_blocked", 32'(in_ready), 0);
        tick();
        chk("post_rst_no_accept", 32'(out_valid), 0);
        in_valid = 1'b0;

        load_all();
        in_valid = 1'b1;
        in_inv   = 1'b0;
        in_data  = pack4(0, 1, 2, 127);
        tick();
        in_valid = 1'b0;
        chk("reload_fwd", 32'(out_data), 32'(pack4(54, 50, 62, 3)));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_engine.md
SBOX_ENGINE -- requirements
Module: sbox_engine

Interface
REQ-001 SHALL have parameter W, default 7, meaning S-box input/output width in bits; table depth is 2^W.
REQ-002 SHALL have parameter LANES, default 1, meaning the number of independent lookups per transaction.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  table write strobe.
REQ-006 wr_addr  input  W  table entry index.
REQ-007 wr_data  input  W  table entry value.
REQ-008 tbl_ready  output  1  high once all 2^W entries have been written since reset.
REQ-009 in_valid  input  1  lookup request valid.
REQ-010 in_ready  output  1  engine accepts a request this cycle.
REQ-011 in_inv  input  1  0 = forward lookup S(x); 1 = inverse lookup S^-1(y).
REQ-012 in_data  input  LANES*W  lookup operands; lane k occupies bits [k*W +: W].
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  LANES*W  results, with the same lane packing as in_data.

Function
REQ-016 SHALL hold a forward table fwd[2^W] and an inverse table inv[2^W], each W bits wide.
REQ-017 A cycle with wr_en=1 SHALL write fwd[wr_addr]<=wr_data and inv[wr_data]<=wr_addr in the same edge.
REQ-018 SHALL count writes in a saturating counter of width W+1; tbl_ready SHALL assert on the cycle after the 2^W-th write and stay high until reset. Duplicate addresses count; correct tables require a permutation loaded in full.
REQ-019 in_ready SHALL equal tbl_ready AND NOT wr_en AND (NOT out_valid OR out_ready).
REQ-020 A transaction SHALL be accepted when in_valid and in_ready are both high.
REQ-021 On acceptance, out_data lane k SHALL load fwd[in_data lane k] if in_inv=0, or inv[in_data lane k] if in_inv=1, and out_valid SHALL set; latency is 1 cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold unchanged.
REQ-023 When out_valid=1, out_ready=1 and there is no new acceptance, out_valid SHALL clear on the next edge.
REQ-024 When a result is consumed and a new request is accepted in the same cycle, the new result SHALL replace it with no bubble, giving a throughput of one transaction per cycle.
REQ-025 Writes take priority over lookups: no acceptance SHALL occur in a cycle with wr_en=1.
REQ-026 A result already held in the output register SHALL NOT change because of later table writes.
REQ-027 in_inv is sampled per transaction only; mixed forward and inverse streams SHALL be supported back-to-back.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, write counter=0, tbl_ready=0, and in_ready=0.
REQ-029 Table contents SHALL NOT be reset; after reset they are treated as invalid until reloaded in full (see REQ-018).
REQ-030 Reset asserted mid-transaction SHALL drop any pending result immediately, without waiting for a clock edge.

Structure
REQ-031 A shared package SHALL hold the default W and LANES values and the lane-slice width constant.
REQ-032 One sub-module, sbox_table, SHALL hold the fwd/inv storage with one write port and LANES combinational read ports per table; sbox_engine holds the counter, handshake and output register.

Verification
REQ-033 Load the KASUMI S7 table (entry 0=54, 1=50, 127=3); tbl_ready rises exactly one cycle after the 128th write; in_ready stays 0 beforehand.
REQ-034 Forward lookup x=0 -> out_data=54 one cycle later; inverse lookup y=54 -> 0; inverse y=3 -> 127.
REQ-035 Hold out_ready=0 with 2 pending requests (x=1, x=2) -> out_data stays 50 and in_ready stays 0; release -> 50, then 62, on consecutive cycles.
REQ-036 LANES=4, in_data lanes {0,1,2,3}, forward -> lanes {54,50,62,56}; streaming 16 back-to-back requests with out_ready=1 -> 16 results on 16 consecutive cycles.
REQ-037 Pulse wr_en (fwd[0]<=5) while in_valid=1 -> no acceptance that cycle; the next forward lookup x=0 -> 5, and inverse y=5 -> 0.
REQ-038 Assert rst_n=0 while out_valid=1 -> out_valid and tbl_ready drop asynchronously; after release, lookups stay blocked until a full reload.
